// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one registered logic unit between two
//   requesters. A winning request is latched in IDLE, issued to the logic unit
//   for one cycle (ISSUE), its result is awaited (WAIT) and returned as a
//   one-cycle response strobe to the requester that won (RESP).
//   Latency: handshake T, LU_ENABLE T+1, capture T+2, RSPn_VALID T+3.
//
// Optional feature:
//   `define ARB_TIMEOUT_EN to add a WAIT watchdog. If LU_OUT_VALID is not seen
//   within TIMEOUT_CYCLES WAIT cycles, the transaction is answered with
//   RSP_ERR=1 and RSP_DATA=0. Without the macro RSP_ERR is tied to 0 and WAIT
//   lasts until LU_OUT_VALID.
//
// Ports:
//   CLK, RST                  clock (rising edge), async active-high reset
//   REQn_VALID/A/B/FUN        request from requester n (n = 0, 1)
//   REQn_READY                request accept (combinational, IDLE only)
//   RSPn_VALID                one-cycle response strobe to requester n
//   RSP_DATA, RSP_ERR         response result / timeout flag
//   LU_A, LU_B, LU_FUN        operands driven to the logic unit
//   LU_ENABLE                 logic-unit enable (ISSUE only)
//   LU_OUT, LU_OUT_VALID      registered result from the logic unit
//   BUSY                      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int A_WIDTH        = 8,
  parameter int B_WIDTH        = 8,
  parameter int OUT_WIDTH      = 8,
  parameter int ALU_FUN_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ0_VALID,
  input  logic [A_WIDTH-1:0]       REQ0_A,
  input  logic [B_WIDTH-1:0]       REQ0_B,
  input  logic [ALU_FUN_WIDTH-1:0] REQ0_FUN,
  output logic                     REQ0_READY,
  input  logic                     REQ1_VALID,
  input  logic [A_WIDTH-1:0]       REQ1_A,
  input  logic [B_WIDTH-1:0]       REQ1_B,
  input  logic [ALU_FUN_WIDTH-1:0] REQ1_FUN,
  output logic                     REQ1_READY,
  output logic                     RSP0_VALID,
  output logic                     RSP1_VALID,
  output logic [OUT_WIDTH-1:0]     RSP_DATA,
  output logic                     RSP_ERR,
  output logic [A_WIDTH-1:0]       LU_A,
  output logic [B_WIDTH-1:0]       LU_B,
  output logic [ALU_FUN_WIDTH-1:0] LU_FUN,
  output logic                     LU_ENABLE,
  input  logic [OUT_WIDTH-1:0]     LU_OUT,
  input  logic                     LU_OUT_VALID,
  output logic                     BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                     state_q;
  logic                       ptr_q;       // requester favoured on contention
  logic                       win_q;       // requester owning the transaction
  logic [A_WIDTH-1:0]         lu_a_q;
  logic [B_WIDTH-1:0]         lu_b_q;
  logic [ALU_FUN_WIDTH-1:0]   lu_fun_q;
  logic                       lu_en_q;
  logic                       rsp0_q;
  logic                       rsp1_q;
  logic [OUT_WIDTH-1:0]       rsp_data_q;
  logic                       rsp_err_q;
  logic                       busy_q;

  logic                       win_s;
  logic                       accept_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]           cnt_q;
`endif

  // Winner selection: a lone requester always wins, contention goes to ptr_q.
  always_comb begin
    win_s = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      win_s = ptr_q;
    end else if (REQ1_VALID) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // READY is gated by RST so that reset forces it low even though the FSM
  // already sits in IDLE while reset is held.
  assign accept_s   = (state_q == ST_IDLE) && !RST && (REQ0_VALID || REQ1_VALID);
  assign REQ0_READY = accept_s && !win_s;
  assign REQ1_READY = accept_s &&  win_s;

  // Arbitration FSM with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      lu_a_q     <= '0;
      lu_b_q     <= '0;
      lu_fun_q   <= '0;
      lu_en_q    <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      // Strobes default low; each is raised for exactly one state.
      lu_en_q <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            win_q    <= win_s;
            lu_a_q   <= win_s ? REQ1_A   : REQ0_A;
            lu_b_q   <= win_s ? REQ1_B   : REQ0_B;
            lu_fun_q <= win_s ? REQ1_FUN : REQ0_FUN;
            lu_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (LU_OUT_VALID) begin
            rsp_data_q <= LU_OUT;
            rsp_err_q  <= 1'b0;
            rsp0_q     <= !win_q;
            rsp1_q     <=  win_q;
            state_q    <= ST_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog expired: answer with an error and a zero result.
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            rsp0_q     <= !win_q;
            rsp1_q     <=  win_q;
            state_q    <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        ST_RESP: begin
          // Hand priority to the requester that was not just served.
          ptr_q   <= ~win_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign LU_A       = lu_a_q;
  assign LU_B       = lu_b_q;
  assign LU_FUN     = lu_fun_q;
  assign LU_ENABLE  = lu_en_q;
  assign RSP0_VALID = rsp0_q;
  assign RSP1_VALID = rsp1_q;
  assign RSP_DATA   = rsp_data_q;
`ifdef ARB_TIMEOUT_EN
  assign RSP_ERR    = rsp_err_q;
`else
  assign RSP_ERR    = 1'b0;
`endif
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ0_VALID, REQ1_VALID;
  logic [7:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [1:0] REQ0_FUN, REQ1_FUN;
  logic       REQ0_READY, REQ1_READY;
  logic       RSP0_VALID, RSP1_VALID;
  logic [7:0] RSP_DATA;
  logic       RSP_ERR;
  logic [7:0] LU_A, LU_B;
  logic [1:0] LU_FUN;
  logic       LU_ENABLE;
  logic [7:0] LU_OUT = 8'h00;
  logic       LU_OUT_VALID = 1'b0;
  logic       BUSY;

  logic       lu_stall = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 CLK = ~CLK;

  logic_unit_arbiter #(
    .A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .ALU_FUN_WIDTH(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .LU_A(LU_A), .LU_B(LU_B), .LU_FUN(LU_FUN), .LU_ENABLE(LU_ENABLE),
    .LU_OUT(LU_OUT), .LU_OUT_VALID(LU_OUT_VALID),
    .BUSY(BUSY)
  );

  // Registered logic-unit model: 00 AND, 01 OR, 10 XOR, 11 NOT A.
  always @(posedge CLK) begin
    LU_OUT_VALID <= LU_ENABLE && !lu_stall;
    case (LU_FUN)
      2'b00:   LU_OUT <= LU_A & LU_B;
      2'b01:   LU_OUT <= LU_A | LU_B;
      2'b10:   LU_OUT <= LU_A ^ LU_B;
      default: LU_OUT <= ~LU_A;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Responses to both requesters must never coincide.
  always @(negedge CLK) begin
    if (RSP0_VALID === 1'b1) chk("rsp_mutex", RSP1_VALID, 1'b0);
  end

  initial begin
    RST = 1'b1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    REQ0_A = 8'h00; REQ0_B = 8'h00; REQ0_FUN = 2'b00;
    REQ1_A = 8'h00; REQ1_B = 8'h00; REQ1_FUN = 2'b00;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state, including READY suppressed while RST is high.
    REQ0_VALID = 1'b1;
    #1;
    chk("rst_ready0", REQ0_READY, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_lu_en", LU_ENABLE, 1'b0);
    chk("rst_rsp0", RSP0_VALID, 1'b0);
    chk("rst_rsp1", RSP1_VALID, 1'b0);
    chk("rst_data", RSP_DATA, 8'h00);
    chk("rst_err", RSP_ERR, 1'b0);
    chk("rst_lu_a", LU_A, 8'h00);
    REQ0_VALID = 1'b0;
    RST = 1'b0;

    // Single REQ0 AND transaction and its latency.
    tick();
    REQ0_VALID = 1'b1; REQ0_A = 8'hF0; REQ0_B = 8'h3C; REQ0_FUN = 2'b00;
    #1;
    chk("t0_ready0", REQ0_READY, 1'b1);
    chk("t0_ready1", REQ1_READY, 1'b0);
    chk("t0_busy", BUSY, 1'b0);
    tick();
    REQ0_VALID = 1'b0;
    #1;
    chk("t1_lu_en", LU_ENABLE, 1'b1);
    chk("t1_lu_a", LU_A, 8'hF0);
    chk("t1_lu_b", LU_B, 8'h3C);
    chk("t1_lu_fun", LU_FUN, 2'b00);
    chk("t1_busy", BUSY, 1'b1);
    tick();
    chk("t2_lu_en", LU_ENABLE, 1'b0);
    chk("t2_rsp0", RSP0_VALID, 1'b0);
    chk("t2_lu_a_hold", LU_A, 8'hF0);
    tick();
    chk("t3_rsp0", RSP0_VALID, 1'b1);
    chk("t3_rsp1", RSP1_VALID, 1'b0);
    chk("t3_data", RSP_DATA, 8'h30);
    chk("t3_err", RSP_ERR, 1'b0);
    tick();
    chk("t4_rsp0", RSP0_VALID, 1'b0);
    chk("t4_busy", BUSY, 1'b0);
    chk("t4_data_hold", RSP_DATA, 8'h30);

    // Both valid after reset: REQ0 OR first, held REQ1 XOR next.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    REQ0_VALID = 1'b1; REQ0_A = 8'hF0; REQ0_B = 8'h0F; REQ0_FUN = 2'b01;
    REQ1_VALID = 1'b1; REQ1_A = 8'hFF; REQ1_B = 8'h0F; REQ1_FUN = 2'b10;
    #1;
    chk("both_ready0", REQ0_READY, 1'b1);
    chk("both_ready1", REQ1_READY, 1'b0);
    tick();
    REQ0_VALID = 1'b0;
    #1;
    chk("busy_ready1", REQ1_READY, 1'b0);
    tick();
    tick();
    chk("both_rsp0", RSP0_VALID, 1'b1);
    chk("both_rsp0_data", RSP_DATA, 8'hFF);
    tick();
    chk("held_ready1", REQ1_READY, 1'b1);
    chk("held_ready0", REQ0_READY, 1'b0);
    tick();
    REQ1_VALID = 1'b0;
    chk("held_lu_fun", LU_FUN, 2'b10);
    chk("held_lu_a", LU_A, 8'hFF);
    tick();
    tick();
    chk("both_rsp1", RSP1_VALID, 1'b1);
    chk("both_rsp1_r0", RSP0_VALID, 1'b0);
    chk("both_rsp1_data", RSP_DATA, 8'hF0);
    tick();

    // Both held valid for four back-to-back transactions: grants 0,1,0,1.
    REQ0_VALID = 1'b1; REQ0_A = 8'hF0; REQ0_B = 8'h3C; REQ0_FUN = 2'b00;
    REQ1_VALID = 1'b1; REQ1_A = 8'hFF; REQ1_B = 8'h0F; REQ1_FUN = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", REQ0_READY, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_ready1", REQ1_READY, (i % 2 == 1) ? 1'b1 : 1'b0);
      tick();
      tick();
      tick();
      chk("rr_rsp0", RSP0_VALID, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_rsp1", RSP1_VALID, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("rr_data", RSP_DATA, (i % 2 == 0) ? 8'h30 : 8'hF0);
      tick();
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

    // Reset during WAIT: pointer moved to 1 first, reset brings it back to 0.
    #1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    chk("pre_ready0", REQ0_READY, 1'b1);
    tick();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick();
    tick();
    tick();
    lu_stall = 1'b1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    #1;
    chk("ptr_ready1", REQ1_READY, 1'b1);
    chk("ptr_ready0", REQ0_READY, 1'b0);
    tick();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick();
    tick();
    tick();
    chk("wait_busy", BUSY, 1'b1);
    chk("wait_rsp1", RSP1_VALID, 1'b0);
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    RST = 1'b1;
    #1;
    chk("mid_ready0", REQ0_READY, 1'b0);
    chk("mid_ready1", REQ1_READY, 1'b0);
    chk("mid_busy", BUSY, 1'b0);
    chk("mid_lu_en", LU_ENABLE, 1'b0);
    chk("mid_lu_a", LU_A, 8'h00);
    chk("mid_lu_fun", LU_FUN, 2'b00);
    chk("mid_data", RSP_DATA, 8'h00);
    chk("mid_err", RSP_ERR, 1'b0);
    tick();
    chk("mid_rsp0", RSP0_VALID, 1'b0);
    chk("mid_rsp1", RSP1_VALID, 1'b0);
    RST = 1'b0;
    lu_stall = 1'b0;
    #1;
    chk("post_ready0", REQ0_READY, 1'b1);
    chk("post_ready1", REQ1_READY, 1'b0);
    tick();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick();
    tick();
    chk("post_rsp0", RSP0_VALID, 1'b1);
    chk("post_data", RSP_DATA, 8'h30);
    tick();

    // Logic unit never answers.
    lu_stall = 1'b1;
    REQ0_VALID = 1'b1;
    #1;
    chk("to_ready0", REQ0_READY, 1'b1);
    tick();
    REQ0_VALID = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait_rsp0", RSP0_VALID, 1'b0);
    end
    tick();
    chk("to_rsp0", RSP0_VALID, 1'b1);
    chk("to_err", RSP_ERR, 1'b1);
    chk("to_data", RSP_DATA, 8'h00);
    tick();
    chk("to_idle", BUSY, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stuck_busy", BUSY, 1'b1);
      chk("stuck_rsp0", RSP0_VALID, 1'b0);
    end
    chk("stuck_err", RSP_ERR, 1'b0);
`endif
    RST = 1'b1;
    tick();
    RST = 1'b0;
    lu_stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter A_WIDTH, default 8, SHALL set the operand A width.
REQ-002 Parameter B_WIDTH, default 8, SHALL set the operand B width.
REQ-003 Parameter OUT_WIDTH, default 8, SHALL set the result width.
REQ-004 Parameter ALU_FUN_WIDTH, default 2, SHALL set the function-code width.
REQ-005 Parameter TIMEOUT_CYCLES, default 8, SHALL set the WAIT watchdog limit (used only under ARB_TIMEOUT_EN).
REQ-006 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-007 Port CLK, input, 1, SHALL be the single clock, rising-edge.
REQ-008 Port RST, input, 1, SHALL be the asynchronous active-high reset.
REQ-009 Ports REQ0_VALID and REQ1_VALID, input, 1 each, SHALL be the request-valid signals.
REQ-010 Ports REQ0_A and REQ1_A, input, A_WIDTH, SHALL carry the request operand A.
REQ-011 Ports REQ0_B and REQ1_B, input, B_WIDTH, SHALL carry the request operand B.
REQ-012 Ports REQ0_FUN and REQ1_FUN, input, ALU_FUN_WIDTH, SHALL carry the request function code.
REQ-013 Ports REQ0_READY and REQ1_READY, output, 1 each, SHALL be the request-accept signals.
REQ-014 Ports RSP0_VALID and RSP1_VALID, output, 1 each, SHALL be single-cycle response strobes.
REQ-015 Port RSP_DATA, output, OUT_WIDTH, SHALL carry the response result.
REQ-016 Port RSP_ERR, output, 1, SHALL flag a timeout response.
REQ-017 Ports LU_A, LU_B and LU_FUN, outputs, A_WIDTH/B_WIDTH/ALU_FUN_WIDTH, SHALL drive the logic-unit operands.
REQ-018 Port LU_ENABLE, output, 1, SHALL be the logic-unit enable.
REQ-019 Ports LU_OUT (input, OUT_WIDTH) and LU_OUT_VALID (input, 1) SHALL carry the logic-unit registered result.
REQ-020 Port BUSY, output, 1, SHALL be high whenever the state is not IDLE.

Function
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-022 In IDLE, when any REQn_VALID is high, exactly one REQn_READY SHALL be asserted combinationally to the round-robin winner; operands SHALL be latched, the winner recorded, and the next state SHALL be ISSUE.
REQ-023 Round-robin: the priority pointer SHALL start at 0 and move to the other requester after each RESP; a lone requester SHALL always win.
REQ-024 READY SHALL be 0 outside IDLE; requests arriving while BUSY SHALL be held by the requester and not dropped.
REQ-025 ISSUE SHALL drive LU_ENABLE=1 with the latched LU_A/LU_B/LU_FUN for exactly one cycle, then go to WAIT; LU_A/LU_B/LU_FUN SHALL hold their latched values until RESP.
REQ-026 WAIT: on LU_OUT_VALID=1, RSP_DATA SHALL capture LU_OUT and the next state SHALL be RESP; otherwise the FSM SHALL stay in WAIT.
REQ-027 RESP SHALL assert the recorded requester's RSPn_VALID for one cycle (no backpressure), with RSP_DATA/RSP_ERR stable; RSP_DATA SHALL hold until the next capture.
REQ-028 Latency: handshake at cycle T, LU_ENABLE at T+1, capture at T+2, RSPn_VALID at T+3; throughput SHALL be one operation per 4 cycles.
REQ-029 RSP0_VALID and RSP1_VALID SHALL never be high together; LU_ENABLE SHALL be 0 outside ISSUE.

Reset
REQ-030 RST high SHALL immediately force every output to 0, the state to IDLE and the pointer to 0.
REQ-031 Reset mid-operation SHALL abort the transaction with no response; after RST deasserts, acceptance SHALL resume from IDLE on the next rising edge.

Configuration
REQ-032 With macro ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; if LU_OUT_VALID is not seen within TIMEOUT_CYCLES cycles, the FSM SHALL go to RESP with RSP_ERR=1 and RSP_DATA=0.
REQ-033 Without ARB_TIMEOUT_EN, the counter SHALL be absent, RSP_ERR SHALL be tied to 0, and WAIT SHALL last until LU_OUT_VALID.

Verification
REQ-034 REQ0 only, A=0xF0, B=0x3C, FUN=00 -> REQ0_READY at T, LU_ENABLE at T+1, RSP0_VALID at T+3 with RSP_DATA=0x30 and RSP_ERR=0.
REQ-035 Both valid after reset; REQ0 FUN=01 with 0xF0/0x0F, REQ1 FUN=10 with 0xFF/0x0F -> RSP0 returns 0xFF, then REQ1 is granted at the next IDLE and RSP1 returns 0xF0.
REQ-036 Both requesters held valid for 4 transactions -> grant order SHALL be 0,1,0,1 with no overlapping responses.
REQ-037 RST pulsed during WAIT -> all outputs 0, no RSPn_VALID; a following simultaneous request SHALL grant REQ0.
REQ-038 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, LU_OUT_VALID stuck 0 -> RSP_ERR=1 and RSP_DATA=0x00 after 4 WAIT cycles; without the macro, BUSY SHALL stay 1 indefinitely.
